// File: rtl/vga_text_pkg.sv
// rtl/vga_text_pkg.sv - shared constants and cell/word types for the text-mode RAM
package vga_text_pkg;

  localparam int ADDR_W     = 12;
  localparam int DATA_W     = 32;
  localparam int TEXT_COLS  = 80;
  localparam int TEXT_ROWS  = 60;
  localparam int WORDS_USED = 2400;
  localparam logic [31:0] CLEAR_WORD = 32'h0F20_0F20;

  typedef struct packed {
    logic [3:0] bg;
    logic [3:0] fg;
    logic [7:0] chr;
  } text_cell_t;

  // Even column lives in the upper halfword.
  typedef struct packed {
    text_cell_t even;
    text_cell_t odd;
  } text_word_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    DONE  = 2'd2
  } clear_state_t;

endpackage

// File: rtl/vga_text_ram_if.sv
// rtl/vga_text_ram_if.sv - CPU write port and display read port bundle
interface vga_text_ram_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
);
  logic [DATA_W/8-1:0] i_wea;
  logic [ADDR_W-1:0]   i_addra;
  logic [DATA_W-1:0]   i_dina;
  logic [ADDR_W-1:0]   i_addrb;
  logic [DATA_W-1:0]   o_doutb;
  logic                o_busy;

  modport master (
    output i_wea, i_addra, i_dina, i_addrb,
    input  o_doutb, o_busy
  );

  modport slave (
    input  i_wea, i_addra, i_dina, i_addrb,
    output o_doutb, o_busy
  );
endinterface

// File: rtl/vga_text_ram_clear.sv
// rtl/vga_text_ram_clear.sv - post-reset clear sweep FSM and address counter
module vga_text_ram_clear
  import vga_text_pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter int DEPTH  = 4096
) (
  input  logic              i_clk_25MHz,
  input  logic              i_rst_n,
  output logic              busy,
  output logic [ADDR_W-1:0] addr
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  clear_state_t      state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge i_clk_25MHz or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    busy    = 1'b0;
    case (state_q)
      IDLE: begin
        state_d = CLEAR;
        cnt_d   = '0;
      end
      CLEAR: begin
        busy  = 1'b1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) state_d = DONE;
      end
      DONE:    state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  assign addr = cnt_q;

endmodule

// File: rtl/vga_text_ram.sv
// rtl/vga_text_ram.sv - dual-port text RAM, optional clear sweep under VGA_TEXT_RAM_CLEAR_EN
module vga_text_ram
  import vga_text_pkg::*;
#(
  parameter int          ADDR_W     = 12,
  parameter int          DATA_W     = 32,
  parameter int          DEPTH      = 4096,
  parameter logic [31:0] CLEAR_WORD = 32'h0F20_0F20
) (
  input  logic          i_clk_25MHz,
  input  logic          i_rst_n,
  vga_text_ram_if.slave bus
);

  localparam int NB    = DATA_W / 8;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_L = DEPTH[ADDR_W:0];

  logic [DATA_W-1:0] mem [DEPTH];

  logic              clr_busy;
  logic [ADDR_W-1:0] clr_addr;

`ifdef VGA_TEXT_RAM_CLEAR_EN
  vga_text_ram_clear #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_clear (
    .i_clk_25MHz (i_clk_25MHz),
    .i_rst_n     (i_rst_n),
    .busy        (clr_busy),
    .addr        (clr_addr)
  );
`else
  assign clr_busy = 1'b0;
  assign clr_addr = '0;
`endif

  assign bus.o_busy = clr_busy;

  logic [NB-1:0]     wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  // The sweep owns the write port outright; CPU writes are dropped while it runs.
  always_comb begin
    wr_en   = bus.i_wea;
    wr_addr = bus.i_addra;
    wr_data = bus.i_dina;
    if (clr_busy) begin
      wr_en   = '1;
      wr_addr = clr_addr;
      wr_data = CLEAR_WORD[DATA_W-1:0];
    end
  end

  always_ff @(posedge i_clk_25MHz) begin
    if (i_rst_n && ({1'b0, wr_addr} < DEPTH_L)) begin
      for (int n = 0; n < NB; n++) begin
        if (wr_en[n]) mem[wr_addr[IDX_W-1:0]][8*n +: 8] <= wr_data[8*n +: 8];
      end
    end
  end

  // Falling-edge read sees any write made at the preceding rising edge.
  always_ff @(negedge i_clk_25MHz or negedge i_rst_n) begin
    if (!i_rst_n) begin
      bus.o_doutb <= '0;
    end else if ({1'b0, bus.i_addrb} < DEPTH_L) begin
      bus.o_doutb <= mem[bus.i_addrb[IDX_W-1:0]];
    end else begin
      bus.o_doutb <= '0;
    end
  end

endmodule

// File: tb/tb_vga_text_ram.sv
// tb/tb_vga_text_ram.sv - directed vector bench for vga_text_ram (clear tests under VGA_TEXT_RAM_CLEAR_EN)
module tb_vga_text_ram;
  import vga_text_pkg::*;

`ifdef VGA_TEXT_RAM_CLEAR_EN
  localparam int TB_DEPTH = 16;
`else
  localparam int TB_DEPTH = 2400;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #20 clk = ~clk;

  vga_text_ram_if #(.ADDR_W(12), .DATA_W(32)) bus ();

  vga_text_ram #(
    .ADDR_W     (12),
    .DATA_W     (32),
    .DEPTH      (TB_DEPTH),
    .CLEAR_WORD (32'h0F20_0F20)
  ) dut (
    .i_clk_25MHz (clk),
    .i_rst_n     (rst_n),
    .bus         (bus)
  );

  typedef struct {
    logic [3:0]  wea;
    logic [11:0] addra;
    logic [31:0] dina;
    logic [11:0] addrb;
    logic [31:0] exp_doutb;
  } vec_t;

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] stream_word(input int i);
    text_word_t w;
    w.even.bg  = 4'(i);
    w.even.fg  = ~4'(i);
    w.even.chr = 8'h41 + 8'(i);
    w.odd.bg   = 4'(i + 3);
    w.odd.fg   = 4'hF;
    w.odd.chr  = 8'h61 + 8'(i);
    return w;
  endfunction

`ifdef VGA_TEXT_RAM_CLEAR_EN
  task automatic count_busy(input string name, output int cnt);
    bit seen;
    cnt  = 0;
    seen = 0;
    for (int c = 0; c < 200; c++) begin
      @(posedge clk); #1;
      if (bus.o_busy) begin
        cnt++;
        seen = 1;
      end else if (seen) begin
        break;
      end
    end
    check(name, 32'(cnt), 32'd16);
  endtask
`endif

  vec_t vecs[12];

  initial begin
    bus.i_wea   = '0;
    bus.i_addra = '0;
    bus.i_dina  = '0;
    bus.i_addrb = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_doutb", bus.o_doutb, 32'h0);
    check("reset_busy", 32'(bus.o_busy), 32'h0);
    @(negedge clk); #1;
    rst_n = 1'b1;

`ifdef VGA_TEXT_RAM_CLEAR_EN
    begin
      int cnt;
      count_busy("busy_len_first", cnt);
      rst_n = 1'b0;
      @(negedge clk); #1;
      rst_n = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check("busy_abort", 32'(bus.o_busy), 32'h0);
      @(negedge clk); #1;
      bus.i_wea   = 4'hF;
      bus.i_addra = 12'd3;
      bus.i_dina  = 32'h1234_5678;
      rst_n = 1'b1;
      count_busy("busy_len_restart", cnt);
      bus.i_wea = '0;
      @(negedge clk); #1;
      for (int a = 0; a < 16; a++) begin
        bus.i_addrb = 12'(a);
        @(negedge clk); #1;
        check($sformatf("clear_word[%0d]", a), bus.o_doutb, 32'h0F20_0F20);
      end
      bus.i_wea   = 4'hF;
      bus.i_addra = 12'd2;
      bus.i_dina  = 32'hCAFE_F00D;
      bus.i_addrb = 12'd2;
      @(negedge clk); #1;
      bus.i_wea = '0;
      check("write_after_done", bus.o_doutb, 32'hCAFE_F00D);
    end
`else
    vecs[0]  = '{4'h0, 12'd0,    32'h0000_0000, 12'd0,    32'h0000_0000};
    vecs[1]  = '{4'hF, 12'd5,    32'h1F41_2E42, 12'd5,    32'h1F41_2E42};
    vecs[2]  = '{4'hF, 12'd7,    32'hAABB_CCDD, 12'd7,    32'hAABB_CCDD};
    vecs[3]  = '{4'h5, 12'd7,    32'h1122_3344, 12'd7,    32'hAA22_CC44};
    vecs[4]  = '{4'hF, 12'd2399, 32'h1234_5678, 12'd2399, 32'h1234_5678};
    vecs[5]  = '{4'hF, 12'd2400, 32'hDEAD_BEEF, 12'd2400, 32'h0000_0000};
    vecs[6]  = '{4'h0, 12'd0,    32'hFFFF_FFFF, 12'd2399, 32'h1234_5678};
    vecs[7]  = '{4'h0, 12'd0,    32'h0000_0000, 12'd5,    32'h1F41_2E42};
    vecs[8]  = '{4'h8, 12'd5,    32'hAB00_0000, 12'd5,    32'hAB41_2E42};
    vecs[9]  = '{4'h0, 12'd0,    32'h0000_0000, 12'd0,    32'h0000_0000};
    vecs[10] = '{4'hF, 12'd4095, 32'hCAFE_F00D, 12'd4095, 32'h0000_0000};
    vecs[11] = '{4'h2, 12'd7,    32'h0000_EE00, 12'd7,    32'hAA22_EE44};

    foreach (vecs[i]) begin
      bus.i_wea   = vecs[i].wea;
      bus.i_addra = vecs[i].addra;
      bus.i_dina  = vecs[i].dina;
      bus.i_addrb = vecs[i].addrb;
      @(negedge clk); #1;
      check($sformatf("vec%0d", i), bus.o_doutb, vecs[i].exp_doutb);
    end
    bus.i_wea = '0;
    check("busy_tied_low", 32'(bus.o_busy), 32'h0);

    for (int i = 0; i < 40; i++) begin
      bus.i_wea   = 4'hF;
      bus.i_addra = 12'(100 + i);
      bus.i_dina  = stream_word(i);
      @(negedge clk); #1;
    end
    bus.i_wea = '0;
    for (int i = 0; i < 40; i++) begin
      bus.i_addrb = 12'(100 + i);
      @(negedge clk); #1;
      check($sformatf("stream[%0d]", i), bus.o_doutb, stream_word(i));
    end

    #5;
    rst_n = 1'b0;
    #1;
    check("async_reset_doutb", bus.o_doutb, 32'h0);
    bus.i_wea   = 4'hF;
    bus.i_addra = 12'd5;
    bus.i_dina  = 32'h0000_0000;
    @(posedge clk); #1;
    bus.i_wea = '0;
    rst_n = 1'b1;
    bus.i_addrb = 12'd5;
    @(negedge clk); #1;
    check("write_in_reset_dropped", bus.o_doutb, 32'hAB41_2E42);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
